// File: rtl/hci_shallow_prio_arbiter_if.sv
// Bundle for the shallow priority arbiter: initiator request/response side and memory side.
// Flat vectors; initiator signals are indexed i*NB_CHAN+c.
interface hci_shallow_prio_arbiter_if #(
   parameter int NB_IN   = 3,
   parameter int NB_CHAN = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int IW      = 8,
   parameter int UW      = 1
);
   localparam int NR = NB_IN * NB_CHAN;

   logic [NR-1:0]          in_req_i;
   logic [NR-1:0]          in_gnt_o;
   logic [NR*AW-1:0]       in_add_i;
   logic [NR-1:0]          in_wen_i;
   logic [NR*DW/8-1:0]     in_be_i;
   logic [NR*DW-1:0]       in_data_i;
   logic [NR*IW-1:0]       in_id_i;
   logic [NR*UW-1:0]       in_user_i;
   logic [NR*DW-1:0]       in_r_data_o;
   logic [NR*IW-1:0]       in_r_id_o;
   logic [NR*UW-1:0]       in_r_user_o;
   logic [NR-1:0]          in_r_valid_o;

   logic [NB_CHAN-1:0]     out_req_o;
   logic [NB_CHAN*AW-1:0]  out_add_o;
   logic [NB_CHAN-1:0]     out_wen_o;
   logic [NB_CHAN*DW/8-1:0] out_be_o;
   logic [NB_CHAN*DW-1:0]  out_data_o;
   logic [NB_CHAN*IW-1:0]  out_id_o;
   logic [NB_CHAN*UW-1:0]  out_user_o;
   logic [NB_CHAN-1:0]     out_gnt_i;
   logic [NB_CHAN*DW-1:0]  out_r_data_i;
   logic [NB_CHAN*IW-1:0]  out_r_id_i;
   logic [NB_CHAN*UW-1:0]  out_r_user_i;

   modport master (
      output in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i, in_id_i, in_user_i,
      input  in_gnt_o, in_r_data_o, in_r_id_o, in_r_user_o, in_r_valid_o,
      input  out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o, out_id_o, out_user_o,
      output out_gnt_i, out_r_data_i, out_r_id_i, out_r_user_i
   );

   modport slave (
      input  in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i, in_id_i, in_user_i,
      output in_gnt_o, in_r_data_o, in_r_id_o, in_r_user_o, in_r_valid_o,
      output out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o, out_id_o, out_user_o,
      input  out_gnt_i, out_r_data_i, out_r_id_i, out_r_user_i
   );
endinterface

// File: rtl/hci_shallow_prio_arbiter.sv
// Per-channel rank arbiter at the SRAM boundary with response owner tracking.
// Define HCI_SHALLOW_PRIO_STALL_CTR_EN to build starvation counters and promotion.
module hci_shallow_prio_arbiter #(
   parameter int NB_IN   = 3,
   parameter int NB_CHAN = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int IW      = 8,
   parameter int UW      = 1,
   parameter int CTR_W   = 8,
   parameter int RW      = $clog2(NB_IN)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   input  logic [NB_IN*RW-1:0]    prio_rank_i,
   input  logic [CTR_W-1:0]       max_stall_i,
   output logic [NB_CHAN*RW-1:0]  owner_o,
   hci_shallow_prio_arbiter_if.slave bus
);
   localparam int BW = DW / 8;
   localparam int NR = NB_IN * NB_CHAN;

   logic              w_hold;
   logic [RW-1:0]     w_win [NB_CHAN];
   logic [NB_CHAN-1:0] w_any;
   logic [NB_CHAN-1:0] w_fire;
   logic [NR-1:0]     w_promo;
   logic [RW-1:0]     r_owner [NB_CHAN];
   logic [NB_CHAN-1:0] r_rv;

   assign w_hold = rst_i | clear_i;

   // Promoted requesters beat everyone else; rank decides inside a class, lower index wins ties.
   always_comb begin
      logic          w_best_p;
      logic [RW-1:0] w_best_rank;
      logic [RW-1:0] w_rank;
      w_win       = '{default: '0};
      w_any       = '0;
      w_best_p    = 1'b0;
      w_best_rank = '0;
      w_rank      = '0;
      for (int c = 0; c < NB_CHAN; c++) begin
         w_best_p    = 1'b0;
         w_best_rank = '0;
         for (int r = 0; r < NB_IN; r++) begin
            w_rank = prio_rank_i[r*RW +: RW];
            if (bus.in_req_i[r*NB_CHAN+c]) begin
               if (!w_any[c] ||
                   (w_promo[r*NB_CHAN+c] && !w_best_p) ||
                   ((w_promo[r*NB_CHAN+c] == w_best_p) && (w_rank < w_best_rank))) begin
                  w_any[c]    = 1'b1;
                  w_best_p    = w_promo[r*NB_CHAN+c];
                  w_best_rank = w_rank;
                  w_win[c]    = RW'(r);
               end
            end
         end
      end
   end

   always_comb begin
      bus.in_gnt_o   = '0;
      bus.out_req_o  = '0;
      bus.out_add_o  = '0;
      bus.out_wen_o  = '0;
      bus.out_be_o   = '0;
      bus.out_data_o = '0;
      bus.out_id_o   = '0;
      bus.out_user_o = '0;
      w_fire         = '0;
      for (int c = 0; c < NB_CHAN; c++) begin
         bus.out_req_o[c] = w_any[c];
         w_fire[c]        = w_any[c] & bus.out_gnt_i[c];
         if (w_any[c]) begin
            bus.out_add_o[c*AW +: AW]  = bus.in_add_i[(int'(w_win[c])*NB_CHAN+c)*AW +: AW];
            bus.out_wen_o[c]           = bus.in_wen_i[int'(w_win[c])*NB_CHAN+c];
            bus.out_be_o[c*BW +: BW]   = bus.in_be_i[(int'(w_win[c])*NB_CHAN+c)*BW +: BW];
            bus.out_data_o[c*DW +: DW] = bus.in_data_i[(int'(w_win[c])*NB_CHAN+c)*DW +: DW];
            bus.out_id_o[c*IW +: IW]   = bus.in_id_i[(int'(w_win[c])*NB_CHAN+c)*IW +: IW];
            bus.out_user_o[c*UW +: UW] = bus.in_user_i[(int'(w_win[c])*NB_CHAN+c)*UW +: UW];
            bus.in_gnt_o[int'(w_win[c])*NB_CHAN+c] = bus.out_gnt_i[c] & ~w_hold;
         end
      end
   end

`ifdef HCI_SHALLOW_PRIO_STALL_CTR_EN
   logic [CTR_W-1:0] r_stall [NR];

   always_ff @(posedge clk_i) begin
      for (int r = 0; r < NB_IN; r++) begin
         for (int c = 0; c < NB_CHAN; c++) begin
            if (w_hold) begin
               r_stall[r*NB_CHAN+c] <= '0;
            end else if (bus.in_req_i[r*NB_CHAN+c] && (w_win[c] != RW'(r))) begin
               if (r_stall[r*NB_CHAN+c] != {CTR_W{1'b1}})
                  r_stall[r*NB_CHAN+c] <= r_stall[r*NB_CHAN+c] + 1'b1;
            end else begin
               r_stall[r*NB_CHAN+c] <= '0;
            end
         end
      end
   end

   always_comb begin
      w_promo = '0;
      for (int k = 0; k < NR; k++)
         w_promo[k] = (max_stall_i != '0) && (r_stall[k] >= max_stall_i);
   end
`else
   logic w_unused_stall;
   assign w_unused_stall = ^max_stall_i;
   assign w_promo        = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (w_hold) begin
         r_rv    <= '0;
         r_owner <= '{default: '0};
      end else begin
         r_rv <= w_fire;
         for (int c = 0; c < NB_CHAN; c++)
            if (w_fire[c]) r_owner[c] <= w_win[c];
      end
   end

   // Outputs are masked while held so a reset right after a grant kills its response valid.
   always_comb begin
      bus.in_r_valid_o = '0;
      bus.in_r_data_o  = '0;
      bus.in_r_id_o    = '0;
      bus.in_r_user_o  = '0;
      owner_o          = '0;
      for (int c = 0; c < NB_CHAN; c++) begin
         owner_o[c*RW +: RW] = w_hold ? '0 : r_owner[c];
         for (int r = 0; r < NB_IN; r++) begin
            bus.in_r_valid_o[r*NB_CHAN+c] = r_rv[c] & ~w_hold & (r_owner[c] == RW'(r));
            bus.in_r_data_o[(r*NB_CHAN+c)*DW +: DW] = bus.out_r_data_i[c*DW +: DW];
            bus.in_r_id_o[(r*NB_CHAN+c)*IW +: IW]   = bus.out_r_id_i[c*IW +: IW];
            bus.in_r_user_o[(r*NB_CHAN+c)*UW +: UW] = bus.out_r_user_i[c*UW +: UW];
         end
      end
   end
endmodule

// File: tb/tb_hci_shallow_prio_arbiter.sv
// Bench for hci_shallow_prio_arbiter: directed vectors, a rule-level model checked every cycle,
// and literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_hci_shallow_prio_arbiter;
   localparam int NB_IN = 3, NB_CHAN = 2, AW = 16, DW = 32, IW = 4, UW = 1, CTR_W = 2, RW = 2;
   localparam int NR = NB_IN * NB_CHAN;
   localparam int SAT = (1 << CTR_W) - 1;

   logic                  clk = 1'b0;
   logic                  rst, clear;
   logic [NB_IN*RW-1:0]   prio_rank;
   logic [CTR_W-1:0]      max_stall;
   logic [NB_CHAN*RW-1:0] owner;
   int                    total = 0;
   int                    bad = 0;
   int                    cyc_n = 0;

   hci_shallow_prio_arbiter_if #(.NB_IN(NB_IN), .NB_CHAN(NB_CHAN), .AW(AW), .DW(DW), .IW(IW), .UW(UW)) bus();

   hci_shallow_prio_arbiter #(.NB_IN(NB_IN), .NB_CHAN(NB_CHAN), .AW(AW), .DW(DW), .IW(IW), .UW(UW),
                              .CTR_W(CTR_W), .RW(RW)) dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .prio_rank_i(prio_rank),
      .max_stall_i(max_stall), .owner_o(owner), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- model: counters per (r,c), pending response per channel
   int cnt [NB_IN][NB_CHAN];
   int m_owner [NB_CHAN];
   bit m_rv [NB_CHAN];

   function automatic int winner(input int c);
      int best = -1;
      int best_key = 1 << 30;
      for (int r = 0; r < NB_IN; r++) begin
         int key;
         bit promo;
`ifdef HCI_SHALLOW_PRIO_STALL_CTR_EN
         promo = (max_stall != 0) && (cnt[r][c] >= int'(max_stall));
`else
         promo = 1'b0;
`endif
         key = (promo ? 0 : 1000) + int'(prio_rank[r*RW +: RW]) * 10 + r;
         if (bus.in_req_i[r*NB_CHAN+c] && key < best_key) begin
            best_key = key;
            best = r;
         end
      end
      return best;
   endfunction

   always @(posedge clk) begin
      int w [NB_CHAN];
      for (int c = 0; c < NB_CHAN; c++) w[c] = winner(c);
      for (int c = 0; c < NB_CHAN; c++) begin
         if (rst || clear) begin
            m_rv[c]    <= 1'b0;
            m_owner[c] <= 0;
         end else begin
            m_rv[c] <= (w[c] >= 0) && bus.out_gnt_i[c];
            if ((w[c] >= 0) && bus.out_gnt_i[c]) m_owner[c] <= w[c];
         end
         for (int r = 0; r < NB_IN; r++) begin
            if (rst || clear) cnt[r][c] <= 0;
            else if (bus.in_req_i[r*NB_CHAN+c] && w[c] != r)
               cnt[r][c] <= (cnt[r][c] < SAT) ? cnt[r][c] + 1 : SAT;
            else cnt[r][c] <= 0;
         end
      end
   end

   always @(negedge clk) begin
      logic [NR-1:0]          e_gnt, e_rv;
      logic [NB_CHAN-1:0]     e_req, e_wen;
      logic [NB_CHAN*AW-1:0]  e_add;
      logic [NB_CHAN*4-1:0]   e_be;
      logic [NB_CHAN*DW-1:0]  e_data;
      logic [NB_CHAN*IW-1:0]  e_id;
      logic [NB_CHAN*UW-1:0]  e_user;
      logic [NB_CHAN*RW-1:0]  e_own;
      logic [NR*DW-1:0]       e_rdata;
      logic [NR*IW-1:0]       e_rid;
      logic [NR*UW-1:0]       e_ruser;
      bit hold;
      int w, k;
      hold = rst || clear;
      {e_gnt, e_rv, e_req, e_wen, e_add, e_be, e_data, e_id, e_user, e_own} = '0;
      {e_rdata, e_rid, e_ruser} = '0;
      for (int c = 0; c < NB_CHAN; c++) begin
         w = winner(c);
         if (w >= 0) begin
            k = w * NB_CHAN + c;
            e_req[c] = 1'b1;
            e_add[c*AW +: AW]  = bus.in_add_i[k*AW +: AW];
            e_wen[c]           = bus.in_wen_i[k];
            e_be[c*4 +: 4]     = bus.in_be_i[k*4 +: 4];
            e_data[c*DW +: DW] = bus.in_data_i[k*DW +: DW];
            e_id[c*IW +: IW]   = bus.in_id_i[k*IW +: IW];
            e_user[c*UW +: UW] = bus.in_user_i[k*UW +: UW];
            e_gnt[k] = bus.out_gnt_i[c] && !hold;
         end
         e_own[c*RW +: RW] = hold ? '0 : RW'(m_owner[c]);
         for (int r = 0; r < NB_IN; r++) begin
            e_rv[r*NB_CHAN+c] = !hold && m_rv[c] && (m_owner[c] == r);
            e_rdata[(r*NB_CHAN+c)*DW +: DW] = bus.out_r_data_i[c*DW +: DW];
            e_rid[(r*NB_CHAN+c)*IW +: IW]   = bus.out_r_id_i[c*IW +: IW];
            e_ruser[(r*NB_CHAN+c)*UW +: UW] = bus.out_r_user_i[c*UW +: UW];
         end
      end
      chk("m_gnt", bus.in_gnt_o, e_gnt);
      chk("m_rvalid", bus.in_r_valid_o, e_rv);
      chk("m_req", bus.out_req_o, e_req);
      chk("m_owner", owner, e_own);
      chk("m_add", bus.out_add_o, e_add);
      chk("m_wen", bus.out_wen_o, e_wen);
      chk("m_be", bus.out_be_o, e_be);
      chk("m_data", bus.out_data_o, e_data);
      chk("m_id", bus.out_id_o, e_id);
      chk("m_user", bus.out_user_o, e_user);
      chk("m_rdata", bus.in_r_data_o, e_rdata);
      chk("m_rid", bus.in_r_id_o, e_rid);
      chk("m_ruser", bus.in_r_user_o, e_ruser);
   end

   // ---------------- stimulus
   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
      bus.out_r_data_i = {16'h5A00 + 16'(cyc_n), 16'hC300 + 16'(cyc_n * 3)};
      bus.out_r_id_i   = 8'(cyc_n * 7);
      bus.out_r_user_i = 2'(cyc_n);
   endtask

   logic [NB_IN*RW-1:0]  t_rank [6] = '{6'b00_01_10, 6'b01_01_01, 6'b00_11_01, 6'b10_00_11, 6'b11_11_11, 6'b00_10_01};
   logic [NR-1:0]        t_req  [6] = '{6'b111111, 6'b111110, 6'b011011, 6'b100101, 6'b000000, 6'b101010};
   logic [NB_CHAN-1:0]   t_gnt  [6] = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b11, 2'b11};
   logic [CTR_W-1:0]     t_max  [6] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd1};

   initial begin
      logic [DW-1:0] rd;
      logic [NR-1:0] exp_g;
      rst = 1'b1; clear = 1'b0; prio_rank = '0; max_stall = '0;
      bus.in_req_i = '0; bus.out_gnt_i = '0;
      bus.out_r_data_i = '0; bus.out_r_id_i = '0; bus.out_r_user_i = '0;
      for (int k = 0; k < NR; k++) begin
         bus.in_add_i[k*AW +: AW]  = 16'hA000 + 16'(k * 273);
         bus.in_wen_i[k]           = (k % 2 == 1);
         bus.in_be_i[k*4 +: 4]     = 4'(k + 1);
         bus.in_data_i[k*DW +: DW] = 32'hD00D0000 + 32'(k * 4097);
         bus.in_id_i[k*IW +: IW]   = 4'(k + 9);
         bus.in_user_i[k]          = (k % 3 == 0);
      end

      // reset with requests present
      cyc(); bus.in_req_i = 6'b111111; bus.out_gnt_i = 2'b11; #2;
      chk("rst_gnt", bus.in_gnt_o, 6'b0);
      chk("rst_rvalid", bus.in_r_valid_o, 6'b0);
      chk("rst_owner", owner, 4'b0);
      chk("rst_req", bus.out_req_o, 2'b11);

      // rank priority: ranks {2,0,1}
      cyc(); rst = 1'b0; prio_rank = 6'b01_00_10; bus.in_req_i = 6'b010101; bus.out_gnt_i = 2'b01; #2;
      chk("rank_gnt", bus.in_gnt_o, 6'b000100);
      cyc(); bus.in_req_i = '0; #2;
      chk("rank_rvalid", bus.in_r_valid_o, 6'b000100);
      chk("rank_owner", owner, 4'b0001);

      // tie-break: ranks {0,0,1}, initiators 0 and 1 on ch1
      cyc(); prio_rank = 6'b01_00_00; bus.in_req_i = 6'b001010; bus.out_gnt_i = 2'b10;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) cyc();
         #2;
         chk("tie_gnt", bus.in_gnt_o, 6'b000010);
      end
      cyc(); bus.in_req_i = '0; #2;
      chk("tie_rvalid", bus.in_r_valid_o, 6'b000010);

      // memory stall on ch0 with initiator 1
      for (int i = 0; i < 2; i++) begin
         cyc(); prio_rank = '0; bus.in_req_i = 6'b000100; bus.out_gnt_i = 2'b00; #2;
         chk("mstall_gnt", bus.in_gnt_o, 6'b0);
         chk("mstall_rvalid", bus.in_r_valid_o, 6'b0);
         chk("mstall_req", bus.out_req_o, 2'b01);
      end
      cyc(); bus.out_gnt_i = 2'b01; #2;
      chk("mstall_gnt_go", bus.in_gnt_o, 6'b000100);
      cyc(); bus.in_req_i = '0; bus.out_r_data_i[31:0] = 32'hCAFE0001; #2;
      rd = bus.in_r_data_o[2*DW +: DW];
      chk("mstall_rvalid_go", bus.in_r_valid_o, 6'b000100);
      chk("mstall_rdata", rd, 32'hCAFE0001);

      // reset in the cycle after a grant (initiator 2, ch1)
      cyc(); bus.in_req_i = 6'b100000; bus.out_gnt_i = 2'b10; #2;
      chk("rg_gnt", bus.in_gnt_o, 6'b100000);
      cyc(); bus.in_req_i = '0; rst = 1'b1; #2;
      chk("rg_rvalid", bus.in_r_valid_o, 6'b0);
      chk("rg_owner", owner, 4'b0);
      cyc(); rst = 1'b0; #2;
      chk("rg_rvalid_after", bus.in_r_valid_o, 6'b0);
      chk("rg_owner_after", owner, 4'b0);

      // starvation: ranks {0,1,2}, max 3, initiators 0 and 2 on ch0
      cyc(); prio_rank = 6'b10_01_00; max_stall = 2'd3; bus.in_req_i = 6'b010001; bus.out_gnt_i = 2'b01;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) cyc();
         #2;
`ifdef HCI_SHALLOW_PRIO_STALL_CTR_EN
         exp_g = (i % 4 == 3) ? 6'b010000 : 6'b000001;
`else
         exp_g = 6'b000001;
`endif
         chk("starve_gnt", bus.in_gnt_o, exp_g);
      end

      // soft clear for one cycle
      cyc(); clear = 1'b1; #2;
      chk("clear_gnt", bus.in_gnt_o, 6'b0);
      chk("clear_rvalid", bus.in_r_valid_o, 6'b0);

      // saturation: loser on ch1 for 10 cycles, then threshold set to the saturated value
      cyc(); clear = 1'b0; max_stall = 2'd0; bus.in_req_i = 6'b001010; bus.out_gnt_i = 2'b10;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) cyc();
         #2;
         chk("sat_gnt", bus.in_gnt_o, 6'b000010);
      end
      cyc(); max_stall = 2'd3; #2;
`ifdef HCI_SHALLOW_PRIO_STALL_CTR_EN
      exp_g = 6'b001000;
`else
      exp_g = 6'b000010;
`endif
      chk("sat_promote", bus.in_gnt_o, exp_g);
      cyc(); #2;
      chk("sat_after", bus.in_gnt_o, 6'b000010);

      // counters cleared by reset
      cyc(); max_stall = 2'd0;
      for (int i = 0; i < 4; i++) cyc();
      rst = 1'b1;
      cyc(); rst = 1'b0; max_stall = 2'd3; #2;
      chk("rst_ctr_gnt", bus.in_gnt_o, 6'b000010);

      // mixed vectors, checked by the model
      for (int t = 0; t < 6; t++) begin
         cyc();
         prio_rank = t_rank[t]; bus.in_req_i = t_req[t]; bus.out_gnt_i = t_gnt[t]; max_stall = t_max[t];
         bus.in_data_i = bus.in_data_i ^ {NR{32'(t * 32'h01010101)}};
         cyc(); cyc();
      end
      cyc(); bus.in_req_i = '0;
      cyc(); cyc();
      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
